mem_port_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares one single-port register-bank memory among NREQ requesters.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter/sequencer that lets NREQ requesters share one
//   single-port register-bank memory. It is the memory's only master.
//   Each transaction runs IDLE -> ISSUE -> (RDWAIT for reads) -> RESP.
//   The operation is latched when the request is granted, and later
//   changes to Req or its operands are ignored.
//
// Ports
//   Clk, Reset_n        clock (rising edge), asynchronous active-low reset
//   Req / Req_RW        per-requester request (hold until own Ack) and
//                       operation (1=write, 0=read)
//   Req_Addr / Req_Din  packed per-requester address and write data
//   Ack                 one-hot, one-cycle completion pulse
//   Rdata               read data, valid in the Ack cycle of a read and held
//                       until the next read completes
//   Busy                high whenever the FSM is not in IDLE
//   Mem_*               memory port (Din/Addr/R_W/Valid out, Dout in)
//
// All outputs are registered.
module mem_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NREQ-1:0]          Req,
  input  logic [NREQ-1:0]          Req_RW,
  input  logic [NREQ*ADDR_W-1:0]   Req_Addr,
  input  logic [NREQ*DATA_W-1:0]   Req_Din,
  output logic [NREQ-1:0]          Ack,
  output logic [DATA_W-1:0]        Rdata,
  output logic                     Busy,
  output logic [DATA_W-1:0]        Mem_Din,
  output logic [ADDR_W-1:0]        Mem_Addr,
  output logic                     Mem_RW,
  output logic                     Mem_Valid,
  input  logic [DATA_W-1:0]        Mem_Dout
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] pick;
  logic [PTR_W-1:0] cand;
  logic             any_req;
  logic [NREQ-1:0]  winner_onehot;

  // Search Ptr, Ptr+1, ... (mod NREQ) for the first set request bit.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PTR_W'((32'(ptr) + k) % NREQ);
      if (!any_req && Req[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    winner_onehot         = '0;
    winner_onehot[winner] = 1'b1;
  end

  // Mem_RW/Mem_Addr/Mem_Din double as the latched operation: they are loaded
  // at grant and simply hold until the next grant.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      winner    <= '0;
      Ack       <= '0;
      Rdata     <= '0;
      Busy      <= 1'b0;
      Mem_Din   <= '0;
      Mem_Addr  <= '0;
      Mem_RW    <= 1'b0;
      Mem_Valid <= 1'b0;
    end else begin
      Ack       <= '0;
      Mem_Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ISSUE;
            winner    <= pick;
            Mem_RW    <= Req_RW[pick];
            Mem_Addr  <= Req_Addr[pick*ADDR_W +: ADDR_W];
            Mem_Din   <= Req_Din[pick*DATA_W +: DATA_W];
            Mem_Valid <= 1'b1;
            Busy      <= 1'b1;
          end
        end
        ISSUE: begin
          if (Mem_RW) begin
            state <= RESP;
            Ack   <= winner_onehot;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          // Memory Dout is registered, so it is valid during this cycle.
          Rdata <= Mem_Dout;
          state <= RESP;
          Ack   <= winner_onehot;
        end
        RESP: begin
          state <= IDLE;
          Busy  <= 1'b0;
          if (winner == PTR_W'(NREQ - 1)) ptr <= '0;
          else                            ptr <= winner + 1'b1;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int NREQ   = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  logic                   Clk = 1'b0;
  logic                   Reset_n = 1'b0;
  logic [NREQ-1:0]        Req = '0;
  logic [NREQ-1:0]        Req_RW = '0;
  logic [NREQ*ADDR_W-1:0] Req_Addr = '0;
  logic [NREQ*DATA_W-1:0] Req_Din = '0;
  logic [NREQ-1:0]        Ack;
  logic [DATA_W-1:0]      Rdata;
  logic                   Busy;
  logic [DATA_W-1:0]      Mem_Din;
  logic [ADDR_W-1:0]      Mem_Addr;
  logic                   Mem_RW;
  logic                   Mem_Valid;
  logic [DATA_W-1:0]      Mem_Dout;

  mem_port_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Req_RW(Req_RW),
    .Req_Addr(Req_Addr), .Req_Din(Req_Din), .Ack(Ack), .Rdata(Rdata),
    .Busy(Busy), .Mem_Din(Mem_Din), .Mem_Addr(Mem_Addr), .Mem_RW(Mem_RW),
    .Mem_Valid(Mem_Valid), .Mem_Dout(Mem_Dout)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  // Register-bank memory attached to the port: registered Dout, reset with the system.
  logic [DATA_W-1:0] mem [256];
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      Mem_Dout <= '0;
    end else if (Mem_Valid) begin
      if (Mem_RW) mem[Mem_Addr] <= Mem_Din;
      else        Mem_Dout <= mem[Mem_Addr];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level arbitration and memory contents.
  typedef struct {
    int                idx;
    bit                rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] rdata;
    bit                first;
  } exp_t;

  exp_t              q[$];
  logic [DATA_W-1:0] ref_mem [256];
  int                ref_ptr = 0;
  logic [DATA_W-1:0] ref_last_rd = '0;

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    ref_ptr = 0;
    ref_last_rd = '0;
  endtask

  // Monitor: pops expectation on each memory issue, completes it on Ack.
  exp_t cur;
  bit   have_cur = 0;
  int   cur_issue = 0;
  int   last_ack = -100;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      have_cur = 0;
      last_ack = -100;
    end else begin
      if (cyc == last_ack + 1) chk("busy_gap", Busy, 0);
      if (Mem_Valid) begin
        chk("busy_in_issue", Busy, 1);
        if (have_cur) chk("issue_overlap", 1, 0);
        if (q.size() == 0) begin
          chk("issue_unexpected", 1, 0);
        end else begin
          cur = q.pop_front();
          have_cur = 1;
          cur_issue = cyc;
          chk("mem_rw", Mem_RW, cur.rw);
          chk("mem_addr", Mem_Addr, cur.addr);
          if (cur.rw) chk("mem_din", Mem_Din, cur.din);
          if (!cur.first) chk("issue_gap", cyc - last_ack, 2);
        end
      end
      if (Ack != '0) begin
        if (!have_cur) begin
          chk("ack_unexpected", Ack, 0);
        end else begin
          chk("ack_vec", Ack, 64'd1 << cur.idx);
          chk("ack_latency", cyc - cur_issue, cur.rw ? 1 : 2);
          chk("rdata", Rdata, cur.rdata);
          chk("busy_in_ack", Busy, 1);
          have_cur = 0;
          last_ack = cyc;
        end
      end
    end
  end

  task automatic scramble(input int i);
    Req_RW[i] = 1'($urandom);
    Req_Addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
    Req_Din[i*DATA_W +: DATA_W] = $urandom;
  endtask

  // Issue a batch of simultaneous requests, each held until its own Ack.
  task automatic run_batch(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] rw,
                           input logic [NREQ*ADDR_W-1:0] addr, input logic [NREQ*DATA_W-1:0] din);
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] done;
    exp_t e;
    int n;
    pend = mask;
    e.first = 1;
    while (pend != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (pend[(ref_ptr + k) % NREQ]) begin
          e.idx = (ref_ptr + k) % NREQ;
          break;
        end
      end
      e.rw   = rw[e.idx];
      e.addr = addr[e.idx*ADDR_W +: ADDR_W];
      e.din  = din[e.idx*DATA_W +: DATA_W];
      if (e.rw) ref_mem[e.addr] = e.din;
      else      ref_last_rd = ref_mem[e.addr];
      e.rdata = ref_last_rd;
      q.push_back(e);
      e.first = 0;
      pend[e.idx] = 1'b0;
      ref_ptr = (e.idx + 1) % NREQ;
    end
    Req_RW = rw; Req_Addr = addr; Req_Din = din; Req = mask;
    done = '0;
    n = 0;
    while (done != mask && n < 60) begin
      @(negedge Clk);
      done = done | (Ack & mask);
      @(posedge Clk); #1;
      Req = mask & ~done;
      for (int i = 0; i < NREQ; i++) if (!Req[i]) scramble(i);
      n++;
    end
    if (done != mask) begin
      chk("batch_timeout", done, mask);
      Req = '0;
    end
  endtask

  task automatic rand_batch(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0]        rw;
    logic [NREQ*ADDR_W-1:0] a;
    logic [NREQ*DATA_W-1:0] d;
    for (int i = 0; i < NREQ; i++) begin
      rw[i] = 1'($urandom);
      a[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 15));
      d[i*DATA_W +: DATA_W] = $urandom;
    end
    run_batch(mask, rw, a, d);
  endtask

  task automatic single(input int i, input bit rw, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    logic [NREQ-1:0]        rwv;
    logic [NREQ*ADDR_W-1:0] a;
    logic [NREQ*DATA_W-1:0] d;
    rwv = '0; a = '0; d = '0;
    rwv[i] = rw;
    a[i*ADDR_W +: ADDR_W] = a1;
    d[i*DATA_W +: DATA_W] = d1;
    run_batch(NREQ'(1) << i, rwv, a, d);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    Req = '0;
    model_reset();
    #1;
    chk("rst_ack", Ack, 0);
    chk("rst_rdata", Rdata, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_mem_valid", Mem_Valid, 0);
    chk("rst_mem_rw", Mem_RW, 0);
    chk("rst_mem_addr", Mem_Addr, 0);
    chk("rst_mem_din", Mem_Din, 0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    int n;
    do_reset();
    @(posedge Clk); #1;

    // Write then read back through a different requester.
    single(0, 1'b1, 8'h10, 32'hDEADBEEF);
    single(1, 1'b0, 8'h10, 32'h0);
    // Pointer now at 2: requesters 0 and 3 together -> 3 first.
    rand_batch(4'b1001);
    // Never-written address reads 0; a following write leaves Rdata alone.
    single(2, 1'b0, 8'hFF, 32'h0);
    single(2, 1'b1, 8'h03, 32'hCAFEF00D);

    // All four right after reset, then 0 again.
    do_reset();
    @(posedge Clk); #1;
    rand_batch(4'b1111);
    rand_batch(4'b0001);

    for (int t = 0; t < 40; t++) rand_batch(NREQ'($urandom_range(1, (1 << NREQ) - 1)));

    // Reset while a read sits in RDWAIT.
    single(1, 1'b1, 8'h05, 32'h12345678);
    single(1, 1'b0, 8'h05, 32'h0);
    e.idx = 1; e.rw = 0; e.addr = 8'h05; e.din = '0; e.rdata = 32'h12345678; e.first = 1;
    q.push_back(e);
    Req_RW[1] = 1'b0;
    Req_Addr[1*ADDR_W +: ADDR_W] = 8'h05;
    Req = 4'b0010;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!Mem_Valid && n < 10);
    if (!Mem_Valid) chk("rdwait_issue_timeout", 0, 1);
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    Req = '0;
    model_reset();
    #1;
    chk("midrst_ack", Ack, 0);
    chk("midrst_mem_valid", Mem_Valid, 0);
    chk("midrst_rdata", Rdata, 0);
    chk("midrst_busy", Busy, 0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    rand_batch(4'b0101);

    repeat (4) @(posedge Clk);
    #1;
    chk("final_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
